// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths and MEM/WB payload layout for the pipeline stages.
package pipeline_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RA_W = 2;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] dm;
    logic [DEF_DATA_W-1:0] alu_ea;
    logic [DEF_RA_W-1:0]   ra;
    logic                  wb_sel;
    logic                  reg_en;
  } memwb_payload_t;
  function automatic int payload_w(int dw, int rw);
    return 2 * dw + rw + 2;
  endfunction
endpackage

// File: rtl/pipeline_mem_wb_if.sv
// pipeline_mem_wb_if: MEM/WB handshake and payload bundle; fwd_* exist only with MEMWB_FWD_EN.
interface pipeline_mem_wb_if #(
  parameter int DATA_W = pipeline_pkg::DEF_DATA_W,
  parameter int RA_W = pipeline_pkg::DEF_RA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] dm;
  logic [DATA_W-1:0] alu_ea;
  logic [RA_W-1:0]   ra;
  logic              wb_sel;
  logic              reg_en;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dm_out;
  logic [DATA_W-1:0] alu_ea_out;
  logic [RA_W-1:0]   ra_out;
  logic              wb_sel_out;
  logic              reg_en_out;
`ifdef MEMWB_FWD_EN
  logic              fwd_valid;
  logic [RA_W-1:0]   fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  modport master (
    output in_valid, dm, alu_ea, ra, wb_sel, reg_en, flush, out_ready,
    input  in_ready, out_valid, dm_out, alu_ea_out, ra_out, wb_sel_out, reg_en_out,
    input  fwd_valid, fwd_addr, fwd_data
  );
  modport slave (
    input  in_valid, dm, alu_ea, ra, wb_sel, reg_en, flush, out_ready,
    output in_ready, out_valid, dm_out, alu_ea_out, ra_out, wb_sel_out, reg_en_out,
    output fwd_valid, fwd_addr, fwd_data
  );
`else
  modport master (
    output in_valid, dm, alu_ea, ra, wb_sel, reg_en, flush, out_ready,
    input  in_ready, out_valid, dm_out, alu_ea_out, ra_out, wb_sel_out, reg_en_out
  );
  modport slave (
    input  in_valid, dm, alu_ea, ra, wb_sel, reg_en, flush, out_ready,
    output in_ready, out_valid, dm_out, alu_ea_out, ra_out, wb_sel_out, reg_en_out
  );
`endif
endinterface

// File: rtl/pipeline_mem_wb_skid.sv
// skid_buffer: two-entry (main + skid) valid/ready register with flush; in_ready comes straight from a flop.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic         accept, xfer;
  assign accept = in_valid_i && !s_valid_q;
  assign xfer = m_valid_q && out_ready_i;
  // M refills from S when full, else from the input when it is empty or draining
  always_comb begin
    m_valid_d = flush_i ? 1'b0 : (accept || s_valid_q || (m_valid_q && !xfer));
    s_valid_d = flush_i ? 1'b0 : ((accept && m_valid_q && !xfer) || (s_valid_q && !xfer));
    m_data_d = flush_i ? m_data_q
             : (s_valid_q && xfer) ? s_data_q
             : (accept && (!m_valid_q || xfer)) ? in_data_i : m_data_q;
    s_data_d = (!flush_i && accept && m_valid_q && !xfer) ? in_data_i : s_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q <= '0;
      s_data_q <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
    end
  end
  assign in_ready_o = !s_valid_q;
  assign out_valid_o = m_valid_q;
  assign out_data_o = m_data_q;
endmodule

// File: rtl/pipeline_mem_wb.sv
// pipeline_mem_wb: MEM/WB stage with skid-buffered handshake and flush.
// Define MEMWB_FWD_EN to add the combinational resolved-result forwarding port.
module pipeline_mem_wb
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W = DEF_RA_W
) (
  input logic               clk,
  input logic               rst,
  pipeline_mem_wb_if.slave  bus
);
  localparam int PW = payload_w(DATA_W, RA_W);
  logic [PW-1:0] in_pl, out_pl;
  // field order matches memwb_payload_t
  assign in_pl = {bus.dm, bus.alu_ea, bus.ra, bus.wb_sel, bus.reg_en};
  skid_buffer #(.W(PW)) u_skid (
    .clk(clk),
    .rst(rst),
    .flush_i(bus.flush),
    .in_valid_i(bus.in_valid),
    .in_ready_o(bus.in_ready),
    .in_data_i(in_pl),
    .out_valid_o(bus.out_valid),
    .out_ready_i(bus.out_ready),
    .out_data_o(out_pl)
  );
  assign {bus.dm_out, bus.alu_ea_out, bus.ra_out, bus.wb_sel_out, bus.reg_en_out} = out_pl;
`ifdef MEMWB_FWD_EN
  assign bus.fwd_valid = bus.out_valid && bus.reg_en_out;
  assign bus.fwd_addr = bus.ra_out;
  assign bus.fwd_data = bus.wb_sel_out ? bus.dm_out : bus.alu_ea_out;
`endif
endmodule

// File: tb/tb_pipeline_mem_wb.sv
// tb_pipeline_mem_wb: directed table, hand sequences and random traffic against a queue model of pipeline_mem_wb.
module tb_pipeline_mem_wb;
  import pipeline_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  memwb_payload_t cur;
  memwb_payload_t q[$];
  pipeline_mem_wb_if #(.DATA_W(8), .RA_W(2)) bus ();
  pipeline_mem_wb #(.DATA_W(8), .RA_W(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       ov;
    logic       ir;
    logic       chk_d;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic memwb_payload_t mk(logic [7:0] v);
    memwb_payload_t p;
    p.dm = v;
    p.alu_ea = ~v;
    p.ra = v[1:0];
    p.wb_sel = v[0];
    p.reg_en = v[1];
    return p;
  endfunction

  function automatic memwb_payload_t got_pl();
    return {bus.dm_out, bus.alu_ea_out, bus.ra_out, bus.wb_sel_out, bus.reg_en_out};
  endfunction

  task automatic drive(logic iv, memwb_payload_t p, logic ordy, logic fl);
    cur = p;
    bus.in_valid = iv;
    bus.dm = p.dm;
    bus.alu_ea = p.alu_ea;
    bus.ra = p.ra;
    bus.wb_sel = p.wb_sel;
    bus.reg_en = p.reg_en;
    bus.out_ready = ordy;
    bus.flush = fl;
  endtask

  // model: the stage is an ordered queue of at most two beats
  task automatic step();
    bit acc, xfer;
    @(posedge clk);
    acc = bus.in_valid && q.size() < 2;
    xfer = q.size() > 0 && bus.out_ready;
    if (bus.flush) q.delete();
    else begin
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    #1;
    chk("model_out_valid", bus.out_valid, q.size() > 0);
    chk("model_in_ready", bus.in_ready, q.size() < 2);
    if (q.size() > 0) chk("model_payload", got_pl(), q[0]);
`ifdef MEMWB_FWD_EN
    chk("model_fwd_valid", bus.fwd_valid, q.size() > 0 && q[0].reg_en);
    if (q.size() > 0) begin
      chk("model_fwd_addr", bus.fwd_addr, q[0].ra);
      chk("model_fwd_data", bus.fwd_data, q[0].wb_sel ? q[0].dm : q[0].alu_ea);
    end
`endif
  endtask

  initial begin
    memwb_payload_t p;
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[3]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22};
    tbl[4]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55};
    tbl[7]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55};
    tbl[8]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_payload", got_pl(), 20'h0);
    rst = 1'b0;

    p.dm = 8'hA5; p.alu_ea = 8'h3C; p.ra = 2'd2; p.wb_sel = 1'b1; p.reg_en = 1'b1;
    drive(1'b1, p, 1'b1, 1'b0);
    step();
    chk("single_out_valid", bus.out_valid, 1'b1);
    chk("single_dm", bus.dm_out, 8'hA5);
    chk("single_alu_ea", bus.alu_ea_out, 8'h3C);
    chk("single_ra", bus.ra_out, 2'd2);
`ifdef MEMWB_FWD_EN
    chk("single_fwd_data", bus.fwd_data, 8'hA5);
    chk("single_fwd_addr", bus.fwd_addr, 2'd2);
`endif
    drive(1'b0, cur, 1'b1, 1'b0);
    step();

    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, mk(8'(i)), 1'b1, 1'b0);
      step();
      chk("b2b_dm", bus.dm_out, i);
      chk("b2b_in_ready", bus.in_ready, 1'b1);
    end
    drive(1'b0, cur, 1'b1, 1'b0);
    step();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].iv, mk(tbl[i].d), tbl[i].ordy, tbl[i].fl);
      step();
      chk("tbl_out_valid", bus.out_valid, tbl[i].ov);
      chk("tbl_in_ready", bus.in_ready, tbl[i].ir);
      if (tbl[i].chk_d) chk("tbl_payload", got_pl(), mk(tbl[i].ed));
    end

    p.dm = 8'h5A; p.alu_ea = 8'h7E; p.ra = 2'd1; p.wb_sel = 1'b0; p.reg_en = 1'b0;
    drive(1'b1, p, 1'b1, 1'b0);
    step();
    chk("noreg_out_valid", bus.out_valid, 1'b1);
`ifdef MEMWB_FWD_EN
    chk("noreg_fwd_valid", bus.fwd_valid, 1'b0);
    chk("noreg_fwd_data", bus.fwd_data, 8'h7E);
`endif
    drive(1'b0, cur, 1'b1, 1'b0);
    step();

    drive(1'b1, mk(8'h91), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(8'h92), 1'b0, 1'b0);
    step();
    chk("full_in_ready", bus.in_ready, 1'b0);
    drive(1'b0, cur, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_in_ready", bus.in_ready, 1'b1);
    chk("arst_payload", got_pl(), 20'h0);
    q.delete();
    #1 rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, memwb_payload_t'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
